// File: rtl/rtc_adj_ctrl_if.sv
// ============================================================================
// Module      : rtc_adj_ctrl_if
// Description : Host, servo and rtc load/adjust signal bundle for rtc_adj_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rtc_adj_ctrl_if;
    // host register path
    logic        h_req;
    logic        h_type;
    logic [47:0] h_sec;
    logic [37:0] h_ns;
    logic [39:0] h_period;
    logic        h_ack;
    // servo path
    logic        s_req;
    logic [47:0] s_offset;
    logic [31:0] s_gap;
    logic        s_ack;
    logic        s_done;
    logic        s_abort;
    logic        busy;
    // rtc load/adjust ports
    logic        time_ld;
    logic [37:0] time_reg_ns_in;
    logic [47:0] time_reg_sec_in;
    logic        period_ld;
    logic [39:0] period_in;
    logic        adj_ld;
    logic [31:0] adj_ld_data;
    logic [39:0] period_adj;
    logic        adj_ld_done;

    modport master (
        output h_req, h_type, h_sec, h_ns, h_period,
        output s_req, s_offset, s_gap,
        output adj_ld_done,
        input  h_ack, s_ack, s_done, s_abort, busy,
        input  time_ld, time_reg_ns_in, time_reg_sec_in,
        input  period_ld, period_in, adj_ld, adj_ld_data, period_adj
    );

    modport slave (
        input  h_req, h_type, h_sec, h_ns, h_period,
        input  s_req, s_offset, s_gap,
        input  adj_ld_done,
        output h_ack, s_ack, s_done, s_abort, busy,
        output time_ld, time_reg_ns_in, time_reg_sec_in,
        output period_ld, period_in, adj_ld, adj_ld_data, period_adj
    );
endinterface

`default_nettype wire

// File: rtl/rtc_adj_ctrl.sv
// ============================================================================
// Module      : rtc_adj_ctrl
// Description : Arbitrates host ToD/period loads against servo phase offsets,
//               slicing offsets into bounded period_adj steps for the rtc.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_adj_ctrl #(
    parameter logic [39:0] STEP_MAX = 40'h00_8000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    rtc_adj_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT_LO = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_ARB     = 3'd4;

    localparam logic signed [47:0] c_step_pos = {8'd0, STEP_MAX};
    localparam logic signed [47:0] c_step_neg = -c_step_pos;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic signed [47:0] r_rem;
    logic signed [47:0] w_rem;
    logic [31:0]        r_gap;
    logic [31:0]        w_gap;

    logic        r_h_ack,     w_h_ack;
    logic        r_s_ack,     w_s_ack;
    logic        r_s_done,    w_s_done;
    logic        r_s_abort,   w_s_abort;
    logic        r_busy,      w_busy;
    logic        r_time_ld,   w_time_ld;
    logic [37:0] r_time_ns,   w_time_ns;
    logic [47:0] r_time_sec,  w_time_sec;
    logic        r_period_ld, w_period_ld;
    logic [39:0] r_period_in, w_period_in;
    logic        r_adj_ld,    w_adj_ld;
    logic [31:0] r_adj_data,  w_adj_data;
    logic [39:0] r_period_adj, w_period_adj;

    logic               w_host_go;
    logic               w_host_serve;
    logic               w_serv_go;
    logic               w_rem_zero;
    logic [39:0]        w_step;
    logic signed [47:0] w_rem_next;

    // A request still visible while its ack is on the wire is the same request.
    assign w_host_go    = bus.h_req && !r_h_ack;
    assign w_serv_go    = bus.s_req && !r_s_ack;
    assign w_host_serve = w_host_go && ((r_state == S_IDLE) || (r_state == S_ARB));
    assign w_rem_zero   = (r_rem == 48'sd0);

    always_comb begin
        w_step = r_rem[39:0];
        if (r_rem > c_step_pos) begin
            w_step = STEP_MAX;
        end else if (r_rem < c_step_neg) begin
            w_step = -STEP_MAX;
        end
    end

    // |step| <= STEP_MAX < 2^39, so sign-extending the 40-bit step is exact.
    assign w_rem_next = r_rem - $signed({{8{w_step[39]}}, w_step});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_host_go && w_serv_go) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = w_rem_zero ? S_IDLE : S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!bus.adj_ld_done) begin
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (bus.adj_ld_done) begin
                    w_state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (w_host_go) begin
                    w_state_nxt = bus.h_type ? S_ISSUE : S_IDLE;
                end else begin
                    w_state_nxt = w_rem_zero ? S_IDLE : S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rem        = r_rem;
        w_gap        = r_gap;
        w_h_ack      = 1'b0;
        w_s_ack      = 1'b0;
        w_s_done     = 1'b0;
        w_s_abort    = 1'b0;
        w_time_ld    = 1'b0;
        w_period_ld  = 1'b0;
        w_adj_ld     = 1'b0;
        w_time_ns    = r_time_ns;
        w_time_sec   = r_time_sec;
        w_period_in  = r_period_in;
        w_adj_data   = r_adj_data;
        w_period_adj = r_period_adj;
        w_busy       = (w_state_nxt != S_IDLE);

        if (w_host_serve) begin
            w_h_ack = 1'b1;
            if (bus.h_type) begin
                w_period_ld = 1'b1;
                w_period_in = bus.h_period;
            end else begin
                w_time_ld  = 1'b1;
                w_time_ns  = bus.h_ns;
                w_time_sec = bus.h_sec;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (!w_host_go && w_serv_go) begin
                    w_rem   = bus.s_offset;
                    w_gap   = bus.s_gap;
                    w_s_ack = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_rem_zero) begin
                    w_s_done     = 1'b1;
                    w_period_adj = '0;
                end else begin
                    w_period_adj = w_step;
                    w_adj_data   = r_gap;
                    w_adj_ld     = 1'b1;
                    w_rem        = w_rem_next;
                end
            end
            S_ARB: begin
                if (w_host_go) begin
                    // A new ToD invalidates whatever phase error remains.
                    if (!bus.h_type) begin
                        w_rem        = '0;
                        w_s_done     = 1'b1;
                        w_s_abort    = 1'b1;
                        w_period_adj = '0;
                    end
                end else if (w_rem_zero) begin
                    w_s_done     = 1'b1;
                    w_period_adj = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_gap        <= '0;
            r_h_ack      <= 1'b0;
            r_s_ack      <= 1'b0;
            r_s_done     <= 1'b0;
            r_s_abort    <= 1'b0;
            r_busy       <= 1'b0;
            r_time_ld    <= 1'b0;
            r_time_ns    <= '0;
            r_time_sec   <= '0;
            r_period_ld  <= 1'b0;
            r_period_in  <= '0;
            r_adj_ld     <= 1'b0;
            r_adj_data   <= '0;
            r_period_adj <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rem        <= w_rem;
            r_gap        <= w_gap;
            r_h_ack      <= w_h_ack;
            r_s_ack      <= w_s_ack;
            r_s_done     <= w_s_done;
            r_s_abort    <= w_s_abort;
            r_busy       <= w_busy;
            r_time_ld    <= w_time_ld;
            r_time_ns    <= w_time_ns;
            r_time_sec   <= w_time_sec;
            r_period_ld  <= w_period_ld;
            r_period_in  <= w_period_in;
            r_adj_ld     <= w_adj_ld;
            r_adj_data   <= w_adj_data;
            r_period_adj <= w_period_adj;
        end
    end

    assign bus.h_ack           = r_h_ack;
    assign bus.s_ack           = r_s_ack;
    assign bus.s_done          = r_s_done;
    assign bus.s_abort         = r_s_abort;
    assign bus.busy            = r_busy;
    assign bus.time_ld         = r_time_ld;
    assign bus.time_reg_ns_in  = r_time_ns;
    assign bus.time_reg_sec_in = r_time_sec;
    assign bus.period_ld       = r_period_ld;
    assign bus.period_in       = r_period_in;
    assign bus.adj_ld          = r_adj_ld;
    assign bus.adj_ld_data     = r_adj_data;
    assign bus.period_adj      = r_period_adj;

endmodule

`default_nettype wire

// File: doc/rtc_adj_ctrl.md
Name: rtc_adj_ctrl

Overview:
- Command controller and arbiter for the RTC load/adjust ports (time_ld, period_ld, adj_ld, period_adj).
- Two requesters share the RTC:
  - Host register path: direct ToD set and period set.
  - Servo: signed phase-offset correction.
- Large offsets are sliced into bounded per-step period_adj corrections, each issued through the adj_ld / adj_ld_done handshake.
- Sits between the CSR/servo logic and the rtc instance, in the same clock domain.

Parameters:
STEP_MAX  40'h00_8000_0000  max magnitude of one step, ns.frac 8.32 format (default 0.5 ns); must be nonzero and < 2^39

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
h_req  in  1  host request, level; held until h_ack
h_type  in  1  0 = time set, 1 = period set
h_sec  in  48  seconds for time set
h_ns  in  38  ns.frac (37:8 ns, 7:0 frac) for time set
h_period  in  40  period (39:32 ns, 31:0 frac) for period set
h_ack  out  1  one-cycle pulse: host command issued
s_req  in  1  servo request, level; held until s_ack
s_offset  in  48  signed two's-complement offset, 47:32 ns, 31:0 frac
s_gap  in  32  adj_ld_data used for every step of this request
s_ack  out  1  one-cycle pulse: offset accepted
s_done  out  1  one-cycle pulse: adjustment finished or aborted
s_abort  out  1  valid with s_done; 1 = remainder discarded by host time set
busy  out  1  servo adjustment in progress (not IDLE)
time_ld  out  1  to rtc
time_reg_ns_in  out  38  to rtc
time_reg_sec_in  out  48  to rtc
period_ld  out  1  to rtc
period_in  out  40  to rtc
adj_ld  out  1  to rtc
adj_ld_data  out  32  to rtc
period_adj  out  40  to rtc
adj_ld_done  in  1  from rtc; 1 when its adjust counter is idle

Behaviour:
- All outputs are registered. On reset every output is 0, FSM = IDLE, rem = 0.
- FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, ARB.
- Host service (one-cycle action, allowed only in IDLE or ARB):
  - If h_req is sampled, next cycle pulse h_ack together with time_ld (h_ns/h_sec captured) or period_ld (h_period captured).
  - Data outputs hold their last value afterwards.
  - The host has strict priority over the servo.
- IDLE:
  - h_req: serve host, stay IDLE.
  - Else s_req: rem <= s_offset, gap <= s_gap, pulse s_ack, go ISSUE.
- ISSUE:
  - step = clamp(rem, -STEP_MAX, +STEP_MAX).
  - If rem == 0: pulse s_done (s_abort = 0), set period_adj <= 0, go IDLE; no adj_ld is issued. This is the zero-offset case.
  - Else: period_adj <= step[39:0] (two's complement; the rtc adder wraps mod 2^40, so negative steps subtract), adj_ld_data <= gap, adj_ld pulse for 1 cycle, rem <= rem - step, go WAIT_LO.
- WAIT_LO: wait for adj_ld_done == 0, then go WAIT_HI.
  - Per the rtc, done drops 2 cycles after adj_ld and stays low gap+1 cycles.
  - period_adj stays stable throughout.
- WAIT_HI: wait for adj_ld_done == 1, then go ARB.
- ARB:
  - If h_req: serve host.
    - Time set: rem <= 0; pulse s_done with s_abort = 1 in the same cycle as h_ack; period_adj <= 0; go IDLE.
    - Period set: go ISSUE (the adjustment resumes with the remainder).
  - Else if rem == 0: pulse s_done (s_abort = 0), period_adj <= 0, go IDLE.
  - Else go ISSUE.
- An s_req arriving while busy is not acked until the FSM returns to IDLE.
- Arithmetic:
  - rem is 48-bit signed.
  - The clamp compares against STEP_MAX zero-extended to 48 bits, and against its negation.
  - Steps are whole STEP_MAX except the last, which carries the residue. Sum of issued steps equals s_offset exactly.
- Reset mid-operation: the FSM returns to IDLE immediately, any pending pulse is lost, and no s_done is issued. The requester must re-request.
- Simultaneous h_req and s_req in IDLE: the host is served first; the servo is acked in the next IDLE cycle if still requesting.

Test Plan:
- s_offset = +1.25 ns (48'h1_4000_0000), s_gap = 0, STEP_MAX default, rtc model attached -> 3 adj_ld pulses; period_adj = 40'h00_8000_0000, 40'h00_8000_0000, then 40'h00_4000_0000; then s_done = 1 with s_abort = 0; rtc time advanced by 1.25 ns vs. reference.
- s_offset = -0.75 ns -> period_adj = 40'hFF_8000_0000, then 40'hFF_C000_0000; s_done; final period_adj = 0.
- s_offset = 0 -> s_ack, s_done one cycle later, no adj_ld.
- h_req and s_req asserted in the same cycle, h_type = 1, h_period = 40'h08_0000_0000 -> period_ld + h_ack first with period_in = 40'h08_0000_0000; s_ack on the next IDLE cycle.
- Mid-adjust of a +2 ns offset, host time set h_sec = 5, h_ns = 0 -> served only in ARB; time_ld, h_ack, s_done and s_abort all pulse together; no further adj_ld.
- rst_n asserted in WAIT_LO -> all outputs 0 asynchronously; after release busy = 0 and no s_done.
